// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop synchronizer, oversampled majority-vote sampling,
// parity/stop checking, registered one-cycle result strobes.
`timescale 1ns/1ps
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);
   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0]        BIT_LAST = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0]        BIT_ONE  = BCW'(1);
   localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state_q;
   logic                    rx_meta_q, rx_s_q;
   logic [PRESCALE_W-1:0]   pres_q, pres_d, edge_cnt_q;
   logic [BCW-1:0]          bit_cnt_q;
   logic [2:0]              samp_q;
   logic                    par_en_q, par_typ_q, par_flag_q;
   logic [DATA_WIDTH-1:0]   shift_q, p_data_q;
   logic                    data_valid_q, par_err_q, stp_err_q;

   logic [PRESCALE_W-1:0]   mid, last_edge;
   logic                    bit_end, bit_val;

   // Unsupported prescale values fall back to 8x oversampling.
   always_comb begin
      pres_d = PRESCALE_W'(8);
      if (prescale == PRESCALE_W'(16) || prescale == PRESCALE_W'(32))
         pres_d = prescale;
   end

   assign mid       = pres_q >> 1;
   assign last_edge = pres_q - ONE;
   assign bit_end   = (edge_cnt_q == last_edge);
   assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         pres_q       <= '0;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         samp_q       <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_flag_q   <= 1'b0;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         rx_meta_q    <= RX_IN;
         rx_s_q       <= rx_meta_q;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;

         if (state_q != IDLE) begin
            if (edge_cnt_q == mid - ONE) samp_q[0] <= rx_s_q;
            if (edge_cnt_q == mid)       samp_q[1] <= rx_s_q;
            if (edge_cnt_q == mid + ONE) samp_q[2] <= rx_s_q;
            edge_cnt_q <= bit_end ? '0 : edge_cnt_q + ONE;
         end

         case (state_q)
            IDLE: begin
               // The detection cycle itself counts as edge 0 of the start bit.
               if (!rx_s_q) begin
                  state_q    <= START;
                  edge_cnt_q <= ONE;
                  pres_q     <= pres_d;
                  par_en_q   <= PAR_EN;
                  par_typ_q  <= PAR_TYP;
               end
            end
            START: begin
               if (bit_end) begin
                  if (bit_val) begin
                     state_q <= IDLE;
                  end else begin
                     state_q    <= DATA;
                     bit_cnt_q  <= '0;
                     par_flag_q <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q <= '0;
                     state_q   <= par_en_q ? PARITY : STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_ONE;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  par_flag_q <= bit_val ^ (^shift_q) ^ par_typ_q;
                  state_q    <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state_q <= IDLE;
                  if (par_flag_q) begin
                     par_err_q <= 1'b1;
                  end else if (!bit_val) begin
                     stp_err_q <= 1'b1;
                  end else begin
                     data_valid_q <= 1'b1;
                     p_data_q     <= shift_q;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign P_DATA     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frames for uart_rx against a frame-level
// event model (expected strobe kind, cycle and P_DATA per frame).
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int DW = 8;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] prescale = PW'(8);
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          data_valid, par_err, stp_err;

   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] p_model = '0;

   typedef struct {
      int            cyc;
      logic [2:0]    kind;
      logic [DW-1:0] data;
   } ev_t;

   ev_t exp_q[$];
   ev_t act_q[$];

   uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX_IN      (RX_IN),
      .prescale   (prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      ev_t e;
      if (rst_n && (data_valid || par_err || stp_err)) begin
         e.cyc  = cyc;
         e.kind = {data_valid, par_err, stp_err};
         e.data = P_DATA;
         act_q.push_back(e);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int p, input bit glitch);
      for (int j = 0; j < p; j++) begin
         RX_IN = (glitch && j == p / 2) ? 1'b0 : b;
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One frame on the pin; the receiver sees it 2 cycles later and reports
   // (start + data + parity + stop) bit periods after that.
   task automatic send_frame(input logic [7:0] d, input int pv, input bit pe, input bit pt,
                             input bit flip, input bit stop_v, input int gbit);
      int   p;
      ev_t  e;
      logic pbit;
      p        = (pv == 16 || pv == 32) ? pv : 8;
      prescale = PW'(pv);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      pbit     = (^d) ^ pt ^ flip;
      e.cyc    = cyc + 2 + (2 + DW + (pe ? 1 : 0)) * p;
      if (pe && (pbit != ((^d) ^ pt))) begin
         e.kind = 3'b010;
      end else if (!stop_v) begin
         e.kind = 3'b001;
      end else begin
         e.kind  = 3'b100;
         p_model = d;
      end
      e.data = p_model;
      exp_q.push_back(e);
      drive_bit(1'b0, p, 1'b0);
      for (int i = 0; i < DW; i++) drive_bit(d[i], p, gbit == i);
      if (pe) drive_bit(pbit, p, 1'b0);
      drive_bit(stop_v, p, 1'b0);
   endtask

   task automatic flush(input string tag);
      check({tag, "_count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         check({tag, "_cyc"},  act_q[i].cyc,  exp_q[i].cyc);
         check({tag, "_kind"}, act_q[i].kind, exp_q[i].kind);
         check({tag, "_data"}, act_q[i].data, exp_q[i].data);
      end
      exp_q.delete();
      act_q.delete();
   endtask

   initial begin
      int pv_tab[8];
      pv_tab = '{8, 16, 32, 8, 16, 32, 5, 12};

      repeat (3) @(negedge clk);
      check("rst_pdata", P_DATA, 0);
      check("rst_dv", data_valid, 0);
      check("rst_perr", par_err, 0);
      check("rst_serr", stp_err, 0);
      rst_n = 1'b1;
      idle(4);

      send_frame(8'hA5, 8, 0, 0, 0, 1, -1);
      idle(6);
      flush("t1_a5");

      send_frame(8'h3C, 16, 1, 0, 1, 1, -1);
      idle(6);
      flush("t2_parerr");
      check("t2_pdata_kept", P_DATA, 8'hA5);

      send_frame(8'h81, 8, 0, 0, 0, 0, -1);
      idle(4);
      send_frame(8'h7E, 8, 0, 0, 0, 1, -1);
      idle(6);
      flush("t3_stp");

      prescale = PW'(16);
      RX_IN = 1'b0;
      repeat (3) @(negedge clk);
      idle(40);
      send_frame(8'h12, 16, 0, 0, 0, 1, -1);
      idle(6);
      flush("t4_falsestart");
      check("t4_pdata", P_DATA, 8'h12);

      send_frame(8'h55, 32, 1, 1, 0, 1, -1);
      send_frame(8'hAA, 32, 1, 1, 0, 1, -1);
      idle(6);
      if (act_q.size() >= 2) check("t5_b2b_gap", act_q[1].cyc - act_q[0].cyc, 352);
      else check("t5_b2b_pulses", act_q.size(), 2);
      flush("t5_b2b");

      send_frame(8'hFF, 8, 0, 0, 0, 1, 3);
      idle(6);
      flush("t6_glitch");

      prescale = PW'(8);
      PAR_EN   = 1'b0;
      drive_bit(1'b0, 8, 1'b0);
      drive_bit(1'b1, 8, 1'b0);
      drive_bit(1'b0, 8, 1'b0);
      drive_bit(1'b1, 8, 1'b0);
      rst_n = 1'b0;
      RX_IN = 1'b1;
      #1;
      check("t7_rst_pdata", P_DATA, 0);
      check("t7_rst_dv", data_valid, 0);
      check("t7_rst_perr", par_err, 0);
      check("t7_rst_serr", stp_err, 0);
      p_model = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      send_frame(8'h5A, 8, 0, 0, 0, 1, -1);
      idle(6);
      flush("t7_after_rst");

      for (int k = 0; k < 40; k++) begin
         int  r, gb, pv;
         bit  pe, pt;
         logic [7:0] d;
         d  = 8'($urandom);
         pv = pv_tab[$urandom_range(0, 7)];
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         gb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
         send_frame(d, pv, pe, pt, pe && r == 0, r != 1, gb);
         idle($urandom_range(0, 3));
      end
      idle(10);
      flush("rnd");
      check("final_pdata", P_DATA, p_model);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path: the receiving counterpart of the TX serializer. It recovers frames from the serial line RX_IN and presents the parallel byte on P_DATA with a one-cycle data_valid strobe.
- Frame format: start (0), DATA_WIDTH data bits LSB first, optional parity, one stop (1).
- Oversampled by integer prescale (8/16/32 clk per bit); majority-vote sampling; parity and stop checking.
- Sits between the pad/line and the system control FSM.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of prescale input and edge counter

Ports:
clk  input  1  system clock (oversampling clock)
rst_n  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high, asynchronous to clk
prescale  input  PRESCALE_W  clk cycles per bit: 8, 16 or 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd parity
P_DATA  output  DATA_WIDTH  last correctly received byte
data_valid  output  1  1-cycle strobe, P_DATA updated
par_err  output  1  1-cycle strobe, parity mismatch
stp_err  output  1  1-cycle strobe, stop bit sampled 0

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All registers clear. P_DATA=0, data_valid=0, par_err=0, stp_err=0, FSM=IDLE, synchronizer flops=1.
- RX_IN passes through a 2-flop synchronizer (rx_s). All timing below refers to rx_s; add 2 cycles for the pin.
- prescale, PAR_EN and PAR_TYP are latched on start detection and held for the whole frame. A prescale value other than 8/16/32 is treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 within each bit (P = latched prescale), then wraps to 0 and advances bit_cnt.
  - bit_cnt is wide enough for DATA_WIDTH.
- Sampling: bit value = majority of rx_s at edge_cnt = P/2-1, P/2, P/2+1. It is valid from edge_cnt = P/2+2 onward.
- FSM states:
  - IDLE: rx_s==0 → START; that cycle is edge_cnt=0 of the start bit.
  - START: at edge_cnt=P-1, sampled 1 (glitch) → IDLE with no output strobes; sampled 0 → DATA.
  - DATA: each bit shifts into the deserializer at MSB with right shift, so data is LSB first. After the bit with bit_cnt=DATA_WIDTH-1 ends: → PARITY if PAR_EN, else → STOP.
  - PARITY: expected bit = XOR(data) ^ PAR_TYP. Mismatch sets an internal flag. At end of bit → STOP.
  - STOP: at edge_cnt=P-1 → IDLE, and exactly one of these is registered for 1 cycle:
    - par_err=1, if the parity flag is set; takes priority over stp_err.
    - else stp_err=1, if the stop bit sampled 0.
    - else data_valid=1 and P_DATA <= deserializer.
- Any error: P_DATA keeps its previous value; data_valid stays 0.
- Latency: data_valid rises in the cycle after edge_cnt=P-1 of the stop bit, i.e. (2+DATA_WIDTH+PAR_EN)*P cycles after the START-entry cycle.
- Back-to-back frames: IDLE re-evaluates rx_s on the cycle it is entered, so a start bit immediately following the stop bit is accepted with no lost cycle.
- Line held low (break): produces a stp_err frame, then FSM re-enters START repeatedly. No data_valid is produced.
- Reset mid-frame: immediate abort to IDLE, outputs cleared; no strobe is generated for the partial frame.

Test Plan:
- prescale=8, PAR_EN=0, send 0xA5 → data_valid high exactly 1 cycle, 80 cycles after START entry; P_DATA=0xA5; par_err=stp_err=0.
- prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 1 (correct is 0) → par_err 1-cycle pulse; data_valid=0; P_DATA keeps prior 0xA5.
- prescale=8, PAR_EN=0, send 0x81 with stop=0 → stp_err pulse, no data_valid. Next frame 0x7E with correct stop → data_valid, P_DATA=0x7E.
- prescale=16, drive RX_IN low for 3 cycles then high → FSM returns to IDLE at start-bit end; no strobes. Following valid 0x12 frame → P_DATA=0x12.
- prescale=32, PAR_EN=1, PAR_TYP=1, back-to-back 0x55 then 0xAA (no idle gap) → two data_valid pulses exactly 352 cycles apart; P_DATA=0x55, then 0xAA.
- Single-cycle low glitch on RX_IN at the DATA bit centre sample (prescale=8, byte 0xFF) → majority vote still yields 0xFF. Assert rst_n low mid-DATA → all outputs 0; the next full frame is received correctly.
